// File: rtl/sr_command_generator_pkg.sv
// Shared definitions for the SR command generator.
//   sr_state_e   : command FSM states (IDLE/SETUP/STROBE/HOLD)
//   CMD_SET/RESET: command encoding carried through a sequence
//   DROP_CNT_W   : width of the saturating dropped-event counter
package sr_cmd_pkg;

  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } sr_state_e;

  localparam logic CMD_SET   = 1'b1;
  localparam logic CMD_RESET = 1'b0;

endpackage

// File: rtl/sr_command_generator_if.sv
// Bundle of the request inputs and command/status outputs of
// sr_command_generator.
//   master : drives set_req/reset_req, observes everything else
//   slave  : the generator itself
// Signalling: there is no valid/ready handshake. set_req/reset_req are raw
// levels (a rising edge is a request); S/R are data that is only meaningful
// while e is high; e is a one-way strobe with no back-pressure.
// dbg_state exposes the FSM state for observation only.
interface sr_command_generator_if;
  import sr_cmd_pkg::*;

  logic                  set_req;
  logic                  reset_req;
  logic                  S;
  logic                  R;
  logic                  e;
  logic                  busy;
  logic                  conflict;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic                  expected_q;
  sr_state_e             dbg_state;

  modport master (
    output set_req, reset_req,
    input  S, R, e, busy, conflict, drop_cnt, expected_q, dbg_state
  );

  modport slave (
    input  set_req, reset_req,
    output S, R, e, busy, conflict, drop_cnt, expected_q, dbg_state
  );

endinterface

// File: rtl/sr_input_conditioner.sv
// Request input conditioner: 2-flop synchronizer, optional debounce,
// rising-edge detector producing a one-cycle event.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   req_i          : raw asynchronous request level
//   evt_o          : one-cycle pulse on a rising edge of the conditioned level
// Build option SR_DEBOUNCE_EN: when defined, the conditioned level only
// follows the synchronized input after it has differed from the current
// level for DEBOUNCE_CYCLES consecutive cycles. When undefined the
// conditioned level is the synchronizer output and no counter exists.
module sr_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic req_i,
  output logic evt_o
);

  logic sync1_q;
  logic sync2_q;
  logic level;
  logic prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= req_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef SR_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             cond_q, cond_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt counts consecutive cycles of disagreement; any agreement (a bounce
  // back) restarts it.
  always_comb begin
    cond_d = cond_q;
    cnt_d  = '0;
    if (sync2_q != cond_q) begin
      if (cnt_q == CNT_LAST) begin
        cond_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cond_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      cond_q <= cond_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level = cond_q;
`else
  assign level = sync2_q;
`endif

  // prev starts at 0, so a level already high at reset release is an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign evt_o = level & ~prev_q;

endmodule

// File: rtl/sr_command_generator.sv
// SR command generator: turns set/reset request levels into timed
// S/R/e command sequences for a downstream gated SR flip-flop.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   bus (slave)    : set_req/reset_req in; S, R, e, busy, conflict,
//                    drop_cnt, expected_q, dbg_state out
// Sequence: SETUP (1 cycle, S or R raised) -> STROBE (e high for
// PULSE_CYCLES) -> HOLD (1 cycle) -> IDLE. Events seen while a sequence is
// in flight go to a one-deep pending slot; a pending reset overrides a
// pending set, a set arriving while a reset is pending is discarded, and a
// repeat of the already-pending kind is counted in drop_cnt.
// Build option SR_DEBOUNCE_EN enables input debouncing (see
// sr_input_conditioner).
module sr_command_generator
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 1
) (
  input logic                  clock,
  input logic                  reset_n,
  sr_command_generator_if.slave bus
);

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

  logic set_evt;
  logic reset_evt;

  sr_input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_cond (
    .clock   (clock),
    .reset_n (reset_n),
    .req_i   (bus.set_req),
    .evt_o   (set_evt)
  );

  sr_input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_cond (
    .clock   (clock),
    .reset_n (reset_n),
    .req_i   (bus.reset_req),
    .evt_o   (reset_evt)
  );

  sr_state_e             state_q, state_d;
  logic                  cmd_q, cmd_d;
  logic [3:0]            pulse_cnt_q, pulse_cnt_d;
  logic                  pend_set_q, pend_set_d;
  logic                  pend_rst_q, pend_rst_d;
  logic                  conflict_q, conflict_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  expected_q_q, expected_q_d;
  logic                  s_q, s_d;
  logic                  r_q, r_d;
  logic                  e_q, e_d;

  // Slot contents that incoming events are merged against this cycle.
  logic slot_set;
  logic slot_rst;
  logic store;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    pulse_cnt_d  = pulse_cnt_q;
    pend_set_d   = pend_set_q;
    pend_rst_d   = pend_rst_q;
    conflict_d   = conflict_q | (set_evt & reset_evt);
    drop_cnt_d   = drop_cnt_q;
    expected_q_d = expected_q_q;
    slot_set     = pend_set_q;
    slot_rst     = pend_rst_q;
    store        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_rst_q || pend_set_q) begin
          // Serve the pending command; the slot is then free for any event
          // arriving in this same cycle.
          state_d  = SETUP;
          cmd_d    = pend_rst_q ? CMD_RESET : CMD_SET;
          slot_set = 1'b0;
          slot_rst = 1'b0;
          store    = 1'b1;
        end else if (reset_evt) begin
          state_d = SETUP;
          cmd_d   = CMD_RESET;
        end else if (set_evt) begin
          state_d = SETUP;
          cmd_d   = CMD_SET;
        end
      end
      SETUP: begin
        state_d     = STROBE;
        pulse_cnt_d = '0;
        store       = 1'b1;
      end
      STROBE: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d = HOLD;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
        store = 1'b1;
      end
      HOLD: begin
        state_d      = IDLE;
        expected_q_d = (cmd_q == CMD_SET);
        store        = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (store) begin
      pend_set_d = slot_set;
      pend_rst_d = slot_rst;
      // A simultaneous set is suppressed by the reset, like in IDLE.
      if (reset_evt) begin
        if (slot_rst) begin
          if (drop_cnt_q != DROP_CNT_MAX) drop_cnt_d = drop_cnt_q + 1'b1;
        end else begin
          pend_rst_d = 1'b1;
          pend_set_d = 1'b0;
        end
      end else if (set_evt) begin
        if (slot_set) begin
          if (drop_cnt_q != DROP_CNT_MAX) drop_cnt_d = drop_cnt_q + 1'b1;
        end else if (!slot_rst) begin
          pend_set_d = 1'b1;
        end
      end
    end

    // Outputs are registered copies of the next-state decode, so they change
    // together with the state register. cmd is single-valued, so S and R can
    // never both be high.
    s_d = (state_d != IDLE) && (cmd_d == CMD_SET);
    r_d = (state_d != IDLE) && (cmd_d == CMD_RESET);
    e_d = (state_d == STROBE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cmd_q        <= CMD_RESET;
      pulse_cnt_q  <= '0;
      pend_set_q   <= 1'b0;
      pend_rst_q   <= 1'b0;
      conflict_q   <= 1'b0;
      drop_cnt_q   <= '0;
      expected_q_q <= 1'b0;
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      e_q          <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      pulse_cnt_q  <= pulse_cnt_d;
      pend_set_q   <= pend_set_d;
      pend_rst_q   <= pend_rst_d;
      conflict_q   <= conflict_d;
      drop_cnt_q   <= drop_cnt_d;
      expected_q_q <= expected_q_d;
      s_q          <= s_d;
      r_q          <= r_d;
      e_q          <= e_d;
    end
  end

  assign bus.S          = s_q;
  assign bus.R          = r_q;
  assign bus.e          = e_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.conflict   = conflict_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.expected_q = expected_q_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_sr_command_generator.sv
// Bench for sr_command_generator: directed scenarios plus randomized request
// levels, compared every cycle against a command-level reference model.
module tb_sr_command_generator;
  import sr_cmd_pkg::*;

  localparam int DB    = 16;
  localparam int PULSE = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sr_command_generator_if bus();

  sr_command_generator #(.DEBOUNCE_CYCLES(DB), .PULSE_CYCLES(PULSE)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [13:0] exp_q[$];   // {S,R,e,busy,conflict,expected_q,drop_cnt[7:0]}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Command progress is a phase counter: -1 idle, 0 setup,
  // 1..PULSE strobe, PULSE+1 hold. Pending: 0 none, 1 set, 2 reset.
  int m_ph = -1;
  bit m_cmd_set;
  int m_pend;
  bit m_conf;
  int m_drops;
  bit m_expq;
  bit cond_m[2];
  bit evt_m[2];
  bit hist0[$];
  bit hist1[$];

  function automatic bit hget(input int c, input int idx);
    if (idx < 0) return 1'b0;
    return (c == 0) ? hist0[idx] : hist1[idx];
  endfunction

  task automatic model_reset();
    m_ph = -1; m_cmd_set = 0; m_pend = 0; m_conf = 0; m_drops = 0; m_expq = 0;
    cond_m[0] = 0; cond_m[1] = 0; evt_m[0] = 0; evt_m[1] = 0;
    hist0.delete(); hist1.delete(); exp_q.delete();
  endtask

  task automatic bump_drop();
    if (m_drops < 255) m_drops++;
  endtask

  task automatic slot_events(input bit se, input bit re);
    if (re) begin
      if (m_pend == 2) bump_drop();
      else m_pend = 2;
    end else if (se) begin
      if (m_pend == 1) bump_drop();
      else if (m_pend == 0) m_pend = 1;
    end
  endtask

  // Conditioned level after edge n: synchronized input is the raw input two
  // edges back; with debouncing it flips only when the last DB synchronized
  // samples all disagree with it.
  task automatic cond_update(input int c);
    int n;
    bit cur, nc;
    n = ((c == 0) ? hist0.size() : hist1.size()) - 1;
    cur = cond_m[c];
`ifdef SR_DEBOUNCE_EN
    begin
      bit stable;
      stable = 1'b1;
      for (int k = 0; k < DB; k++) if (hget(c, n - 2 - k) == cur) stable = 1'b0;
      nc = stable ? ~cur : cur;
    end
`else
    nc = hget(c, n - 1);
`endif
    evt_m[c] = nc & ~cur;
    cond_m[c] = nc;
  endtask

  task automatic model_step();
    bit se, re, s, r, e, b;
    se = evt_m[0];
    re = evt_m[1];
    if (se && re) m_conf = 1'b1;
    if (m_ph < 0) begin
      if (m_pend != 0) begin
        m_cmd_set = (m_pend == 1); m_pend = 0; m_ph = 0;
        slot_events(se, re);
      end else if (re) begin
        m_cmd_set = 0; m_ph = 0;
      end else if (se) begin
        m_cmd_set = 1; m_ph = 0;
      end
    end else begin
      if (m_ph == PULSE + 1) begin
        m_expq = m_cmd_set; m_ph = -1;
      end else begin
        m_ph++;
      end
      slot_events(se, re);
    end
    hist0.push_back(bus.set_req);
    hist1.push_back(bus.reset_req);
    cond_update(0);
    cond_update(1);
    b = (m_ph >= 0);
    s = b && m_cmd_set;
    r = b && !m_cmd_set;
    e = (m_ph >= 1) && (m_ph <= PULSE);
    exp_q.push_back({s, r, e, b, m_conf, m_expq, 8'(m_drops)});
  endtask

  // ---------------- driver tasks ----------------
  int cnt_s, cnt_r, cnt_e;

  task automatic tick();
    logic [13:0] v;
    @(posedge clock);
    model_step();
    #1;
    v = exp_q.pop_front();
    check("S", bus.S, v[13]);
    check("R", bus.R, v[12]);
    check("e", bus.e, v[11]);
    check("busy", bus.busy, v[10]);
    check("conflict", bus.conflict, v[9]);
    check("expected_q", bus.expected_q, v[8]);
    check("drop_cnt", bus.drop_cnt, v[7:0]);
    check("s_and_r_excl", bus.S & bus.R, 0);
    check("e_only_strobe", bus.e, (bus.dbg_state == STROBE));
    cnt_s += bus.S;
    cnt_r += bus.R;
    cnt_e += bus.e;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_S"}, bus.S, 0);
    check({tag, "_R"}, bus.R, 0);
    check({tag, "_e"}, bus.e, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_expected_q"}, bus.expected_q, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs_zero("reset");
    check("reset_conflict", bus.conflict, 0);
    check("reset_drop_cnt", bus.drop_cnt, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cnt_s = 0; cnt_r = 0; cnt_e = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [0:11] sp, rp;
    bit found;
    int hold;
    bus.set_req = 1'b0;
    bus.reset_req = 1'b0;
    cnt_s = 0; cnt_r = 0; cnt_e = 0;
    model_reset();
    @(negedge clock);

    // Single set request held for 40 cycles.
    do_reset();
    bus.set_req = 1'b1;
    run(40);
    bus.set_req = 1'b0;
    run(40);
    check("set_s_cycles", cnt_s, PULSE + 2);
    check("set_e_cycles", cnt_e, PULSE);
    check("set_r_cycles", cnt_r, 0);
    check("set_expected_q", bus.expected_q, 1);

    // Set and reset rising together: reset wins, conflict is sticky.
    do_reset();
    bus.set_req = 1'b1;
    bus.reset_req = 1'b1;
    run(40);
    bus.set_req = 1'b0;
    bus.reset_req = 1'b0;
    run(40);
    check("conf_flag", bus.conflict, 1);
    check("conf_expected_q", bus.expected_q, 0);
    check("conf_s_cycles", cnt_s, 0);
    check("conf_r_cycles", cnt_r, PULSE + 2);

    // Events during a set sequence: two reset pulses, one set pulse.
    do_reset();
    sp = 12'b1100_0100_0000;
    rp = 12'b0010_1000_0000;
    for (int k = 0; k < 12; k++) begin
      bus.set_req = sp[k];
      bus.reset_req = rp[k];
      tick();
    end
    run(30);
`ifndef SR_DEBOUNCE_EN
    check("busy_drop_cnt", bus.drop_cnt, 1);
    check("busy_expected_q", bus.expected_q, 0);
    check("busy_s_cycles", cnt_s, PULSE + 2);
    check("busy_r_cycles", cnt_r, PULSE + 2);
`endif

    // set_req toggled every 5 cycles.
    do_reset();
    for (int k = 0; k < 100; k++) begin
      bus.set_req = ((k / 5) % 2) == 0;
      tick();
    end
    bus.set_req = 1'b0;
    run(30);
`ifdef SR_DEBOUNCE_EN
    check("bounce_s_cycles", cnt_s, 0);
    check("bounce_e_cycles", cnt_e, 0);
    check("bounce_drop_cnt", bus.drop_cnt, 0);
`endif

    // Reset asserted in the middle of STROBE.
    do_reset();
    bus.set_req = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      tick();
      if (m_ph == 2) found = 1'b1;
    end
    check("strobe_reached", found, 1);
    bus.set_req = 1'b0;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cnt_e = 0;
    run(40);
    check("abort_no_e", cnt_e, 0);

    // Request level already high when reset is released.
    bus.set_req = 1'b1;
    do_reset();
    run(60);
    check("release_high_expected_q", bus.expected_q, 1);
    bus.set_req = 1'b0;

    // Randomized request levels.
    do_reset();
`ifdef SR_DEBOUNCE_EN
    hold = 30;
`else
    hold = 4;
`endif
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, hold) == 0) bus.set_req = ~bus.set_req;
      if ($urandom_range(0, hold) == 0) bus.reset_req = ~bus.reset_req;
      tick();
    end
    bus.set_req = 1'b0;
    bus.reset_req = 1'b0;
    run(60);

    // Drop counter saturation: reset_req toggles every cycle.
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      bus.reset_req = ~bus.reset_req;
      tick();
    end
    bus.reset_req = 1'b0;
    run(30);
`ifndef SR_DEBOUNCE_EN
    check("drop_cnt_saturated", bus.drop_cnt, 255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sr_command_generator.md
SR_COMMAND_GENERATOR -- requirements
Module: sr_command_generator

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required to accept a request-level change (range 2..255).
REQ-002 Parameter PULSE_CYCLES, default 1, number of cycles e is held high per command (range 1..15).
REQ-003 clock  input  1  single clock, all state rises on posedge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 set_req  input  1  raw, asynchronous set request level (button/switch).
REQ-006 reset_req  input  1  raw, asynchronous reset request level.
REQ-007 S  output  1  set command to the downstream SR flip-flop.
REQ-008 R  output  1  reset command to the downstream SR flip-flop.
REQ-009 e  output  1  enable strobe to the downstream flip-flop (gated with clock downstream).
REQ-010 busy  output  1  high whenever the FSM is not IDLE.
REQ-011 conflict  output  1  sticky: simultaneous set/reset events were seen.
REQ-012 drop_cnt  output  8  saturating count of discarded events.
REQ-013 expected_q  output  1  value the downstream flip-flop holds after the last completed command.

Function
REQ-014 Each request passes a 2-flop synchronizer, then conditioning (REQ-030), then rising-edge detection producing a 1-cycle set_evt / reset_evt.
REQ-015 FSM states IDLE, SETUP, STROBE, HOLD; S/R/e are registered outputs.
REQ-016 IDLE: S=R=e=0; on a served command -> SETUP.
REQ-017 SETUP (1 cycle): selected S or R = 1, the other = 0, e=0 -> STROBE.
REQ-018 STROBE: S/R unchanged, e=1 for exactly PULSE_CYCLES cycles -> HOLD.
REQ-019 HOLD (1 cycle): S/R unchanged, e=0; expected_q updated (1 for set, 0 for reset) -> IDLE.
REQ-020 S and R SHALL never be 1 in the same cycle; S=R=1 is unreachable.
REQ-021 set_evt and reset_evt in the same cycle: reset command served, conflict set to 1 until reset_n.
REQ-022 Event while busy: stored in a one-deep pending slot (set/reset bit), served from IDLE on the cycle after HOLD exits; pending reset beats pending set.
REQ-023 Event arriving while the matching pending bit is already set: dropped, drop_cnt += 1, saturating at 255.
REQ-024 Event arriving in IDLE with an empty pending slot: SETUP entered on the next clock (latency 1 cycle from evt to S/R).
REQ-025 Command sequence length = PULSE_CYCLES + 2 cycles from SETUP entry to IDLE.
REQ-026 Level held high produces exactly one event; re-arm requires deassertion.

Reset
REQ-027 reset_n low: S=R=e=0, busy=0, conflict=0, drop_cnt=0, expected_q=0, state IDLE, pending cleared, synchronizers/debounce state 0, all asynchronously.
REQ-028 Reset mid-command (any non-IDLE state): command aborted, expected_q=0, no e pulse after reset_n release until a new event.
REQ-029 Request levels high at reset_n release: treated as rising edges once conditioned.

Configuration
REQ-030 SR_DEBOUNCE_EN defined: conditioned level changes only after synchronized input differs from the current level for DEBOUNCE_CYCLES consecutive cycles; counter restarts on any bounce.
REQ-031 SR_DEBOUNCE_EN undefined: conditioned level = synchronizer output; DEBOUNCE_CYCLES ignored; no debounce counters synthesized.

Structure
REQ-032 Package sr_cmd_pkg holds the FSM state typedef (IDLE/SETUP/STROBE/HOLD), command encoding constants (CMD_SET, CMD_RESET), and DROP_CNT_W=8.
REQ-033 Sub-module sr_input_conditioner (synchronizer + optional debounce + edge detect) instantiated once per request input.

Verification
REQ-034 set_req held high 40 cycles (debounce on, 16) -> after 2+16 cycles one sequence: S=1 for 3 cycles, e=1 on cycle 2 only, expected_q=1, R=0 throughout.
REQ-035 set_req and reset_req rise in the same cycle -> R=1, S=0 sequence, conflict=1, expected_q=0.
REQ-036 During a set sequence, reset_req pulsed twice and set_req once (all clean) -> set completes, then reset served, then nothing further; drop_cnt=1, expected_q=0.
REQ-037 set_req toggled every 5 cycles for 100 cycles (debounce 16) -> no S/R/e activity, drop_cnt=0.
REQ-038 reset_n asserted during STROBE with PULSE_CYCLES=4 -> S=R=e=0 immediately, expected_q=0, busy=0; no e after release.
REQ-039 All tests: assertion that S&R is never 1 and e=1 only in STROBE.
